// File: rtl/spi_adc_sampler_if.sv
// -----------------------------------------------------------------------------
// spi_adc_sampler_if
// Bundles the sampler's request, ADC serial and sample-result signals.
// Signal names keep the sampler-relative _i/_o suffixes so they line up with
// the sampler's datasheet-style port list.
//
// Modports:
//   slave  : used by spi_adc_sampler (receives tick/enable/miso/clear,
//            drives chip select, serial clock, sample and status)
//   master : used by whatever surrounds the sampler (timer, ADC, datapath)
//
// Signals:
//   enable_i         block enable; low aborts any transfer
//   tick_i           one-cycle sample request from the sampling timer
//   miso_i           ADC serial data
//   clear_overrun_i  synchronous clear for overrun_o
//   cs_n_o           ADC chip select, active low
//   sclk_o           ADC serial clock, idles low
//   sample_o         last completed sample (WORD_LENGTH bits)
//   sample_valid_o   one-cycle pulse, sample_o updated
//   busy_o           high whenever a transfer is in progress
//   overrun_o        sticky tick-while-busy flag
// -----------------------------------------------------------------------------
interface spi_adc_sampler_if #(
   parameter int WORD_LENGTH = 16
);
   logic                   enable_i;
   logic                   tick_i;
   logic                   miso_i;
   logic                   clear_overrun_i;
   logic                   cs_n_o;
   logic                   sclk_o;
   logic [WORD_LENGTH-1:0] sample_o;
   logic                   sample_valid_o;
   logic                   busy_o;
   logic                   overrun_o;

   modport slave (
      input  enable_i, tick_i, miso_i, clear_overrun_i,
      output cs_n_o, sclk_o, sample_o, sample_valid_o, busy_o, overrun_o
   );

   modport master (
      output enable_i, tick_i, miso_i, clear_overrun_i,
      input  cs_n_o, sclk_o, sample_o, sample_valid_o, busy_o, overrun_o
   );
endinterface

// File: rtl/spi_adc_sampler.sv
// -----------------------------------------------------------------------------
// spi_adc_sampler
// On each sampling tick, performs one SPI read of a serial ADC: drops chip
// select, waits CS_SETUP_CYCLES, clocks in WORD_LENGTH bits MSB-first (miso
// sampled on the rising sclk edge) and then presents the word on sample_o with
// a one-cycle sample_valid_o pulse. Ticks arriving while a transfer is in
// progress are dropped.
//
// Optional feature macro: OVERRUN_DETECT_EN
//   defined   : overrun_o is a sticky flag set by a tick seen while busy,
//               cleared by clear_overrun_i (a simultaneous set wins)
//   undefined : overrun_o is tied low and clear_overrun_i is ignored
//
// Ports:
//   clock_i    system clock, all logic on the rising edge
//   reset_n_i  asynchronous active-low reset
//   bus        spi_adc_sampler_if.slave (see interface header for signals)
// -----------------------------------------------------------------------------
module spi_adc_sampler #(
   parameter int WORD_LENGTH     = 16,
   parameter int SCLK_DIVIDE     = 2,
   parameter int CS_SETUP_CYCLES = 2
) (
   input  logic                    clock_i,
   input  logic                    reset_n_i,
   spi_adc_sampler_if.slave        bus
);

   localparam int DIV_W   = (SCLK_DIVIDE > 1)     ? $clog2(SCLK_DIVIDE)     : 1;
   localparam int BIT_W   = (WORD_LENGTH > 1)     ? $clog2(WORD_LENGTH)     : 1;
   localparam int SETUP_W = (CS_SETUP_CYCLES > 1) ? $clog2(CS_SETUP_CYCLES) : 1;

   localparam logic [DIV_W-1:0]   DIV_LAST   = DIV_W'(SCLK_DIVIDE - 1);
   localparam logic [BIT_W-1:0]   BIT_LAST   = BIT_W'(WORD_LENGTH - 1);
   localparam logic [SETUP_W-1:0] SETUP_LAST = SETUP_W'(CS_SETUP_CYCLES - 1);

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] SETUP = 2'd1;
   localparam logic [1:0] SHIFT = 2'd2;
   localparam logic [1:0] DONE  = 2'd3;

   logic [1:0]             state_reg;
   logic [SETUP_W-1:0]     setup_cnt_reg;
   logic [DIV_W-1:0]       div_cnt_reg;
   logic [BIT_W-1:0]       bit_cnt_reg;
   logic [WORD_LENGTH-1:0] shift_reg;
   logic [WORD_LENGTH-1:0] sample_reg;
   logic                   valid_reg;
   logic                   cs_n_reg;
   logic                   sclk_reg;

   // Chip select and sclk are registered so the ADC sees glitch-free lines.
   // The sample register is loaded on the edge that enters DONE, so the data
   // is already in place during the single cycle that valid is high.
   always_ff @(posedge clock_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         state_reg     <= IDLE;
         setup_cnt_reg <= '0;
         div_cnt_reg   <= '0;
         bit_cnt_reg   <= '0;
         shift_reg     <= '0;
         sample_reg    <= '0;
         valid_reg     <= 1'b0;
         cs_n_reg      <= 1'b1;
         sclk_reg      <= 1'b0;
      end else begin
         valid_reg <= 1'b0;
         if ((state_reg != IDLE) && !bus.enable_i) begin
            // Abort: back to idle with the ADC lines released, no valid pulse.
            state_reg     <= IDLE;
            setup_cnt_reg <= '0;
            div_cnt_reg   <= '0;
            bit_cnt_reg   <= '0;
            cs_n_reg      <= 1'b1;
            sclk_reg      <= 1'b0;
         end else begin
            case (state_reg)
               IDLE: begin
                  if (bus.tick_i && bus.enable_i) begin
                     state_reg     <= SETUP;
                     cs_n_reg      <= 1'b0;
                     setup_cnt_reg <= '0;
                  end
               end
               SETUP: begin
                  if (setup_cnt_reg == SETUP_LAST) begin
                     state_reg     <= SHIFT;
                     setup_cnt_reg <= '0;
                     div_cnt_reg   <= '0;
                     bit_cnt_reg   <= '0;
                  end else begin
                     setup_cnt_reg <= setup_cnt_reg + SETUP_W'(1);
                  end
               end
               SHIFT: begin
                  if (div_cnt_reg == DIV_LAST) begin
                     div_cnt_reg <= '0;
                     if (!sclk_reg) begin
                        // Rising sclk: capture miso at the same edge.
                        sclk_reg  <= 1'b1;
                        shift_reg <= {shift_reg[WORD_LENGTH-2:0], bus.miso_i};
                     end else begin
                        sclk_reg <= 1'b0;
                        if (bit_cnt_reg == BIT_LAST) begin
                           bit_cnt_reg <= '0;
                           state_reg   <= DONE;
                           cs_n_reg    <= 1'b1;
                           sample_reg  <= shift_reg;
                           valid_reg   <= 1'b1;
                        end else begin
                           bit_cnt_reg <= bit_cnt_reg + BIT_W'(1);
                        end
                     end
                  end else begin
                     div_cnt_reg <= div_cnt_reg + DIV_W'(1);
                  end
               end
               DONE: begin
                  state_reg <= IDLE;
               end
               default: begin
                  state_reg <= IDLE;
                  cs_n_reg  <= 1'b1;
                  sclk_reg  <= 1'b0;
               end
            endcase
         end
      end
   end

   assign bus.cs_n_o         = cs_n_reg;
   assign bus.sclk_o         = sclk_reg;
   assign bus.sample_o       = sample_reg;
   assign bus.sample_valid_o = valid_reg;
   assign bus.busy_o         = (state_reg != IDLE);

`ifdef OVERRUN_DETECT_EN
   logic overrun_reg;

   // Set has priority over clear so a tick dropped in the clearing cycle
   // is never lost.
   always_ff @(posedge clock_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         overrun_reg <= 1'b0;
      end else if (bus.tick_i && bus.enable_i && (state_reg != IDLE)) begin
         overrun_reg <= 1'b1;
      end else if (bus.clear_overrun_i) begin
         overrun_reg <= 1'b0;
      end
   end

   assign bus.overrun_o = overrun_reg;
`else
   assign bus.overrun_o = 1'b0;
`endif

endmodule
